pc_unit: RTL
============

// Module: pc_unit
// PURPOSE
//  Parametrised fetch program-counter unit; next generation of the core's PC register.
//  Holds the fetch PC and advances it on a valid/ready fetch handshake.
//  Applies trap and branch/jump redirects with fixed priority, and flags misaligned redirect targets.
//  Provides a boot-delay state after reset and a debug halt/resume state. Sits between the IF stage and IMEM.
// PARAMETERS
//  XLEN          32            PC width in bits
//  RESET_VECTOR  32'h8000_0000 PC value loaded on reset; must be aligned
//  ALIGN_LOG2    2             required target alignment (2 = 4-byte, 1 = 2-byte for RVC)
//  BOOT_DELAY    4             cycles in BOOT before first fetch (>=1)
// PORTS
//  clk             in  1     clock, rising edge
//  rst             in  1     asynchronous, active-high reset
//  en              in  1     pipeline enable; 0 = stall sequential advance only
//  fetch_ready_i   in  1     IMEM accepts the current PC
//  fetch_valid_o   out 1     pc_o is a valid fetch request
//  pc_o            out XLEN  current fetch PC
//  redirect_i      in  1     branch/jump redirect strobe from EX
//  redirect_pc_i   in  XLEN  redirect target
//  trap_i          in  1     trap/exception redirect strobe
//  trap_vec_i      in  XLEN  trap vector (low ALIGN_LOG2 bits are ignored)
//  halt_req_i      in  1     debug halt request (level)
//  resume_i        in  1     debug resume strobe
//  halted_o        out 1     unit is in HALT
//  misalign_o      out 1     one-cycle pulse: rejected misaligned redirect
//  misalign_addr_o out XLEN  offending target; holds until the next misalign
// BEHAVIOUR
//  Reset (async, any state): state=BOOT, pc_o=RESET_VECTOR, boot counter=BOOT_DELAY-1.
//   fetch_valid_o=0, halted_o=0, misalign_o=0, misalign_addr_o=0.
//  FSM states BOOT/RUN/HALT. fetch_valid_o = (state==RUN), registered-state decode.
//  BOOT: counter decrements each cycle; counter==0 -> RUN next cycle.
//   Redirect, trap and halt are ignored in BOOT.
//   First fetch_valid_o is asserted exactly BOOT_DELAY cycles after rst deasserts.
//  RUN, per cycle, priority order (one action only):
//   1. trap_i: pc <= {trap_vec_i[XLEN-1:ALIGN_LOG2], 0s}.
//   2. redirect_i, target aligned: pc <= redirect_pc_i.
//   2b. redirect_i, misaligned (redirect_pc_i[ALIGN_LOG2-1:0]!=0): pc unchanged;
//       misalign_o=1 next cycle; misalign_addr_o <= redirect_pc_i.
//   3. en & fetch_ready_i: pc <= pc + 4 (mod 2^XLEN; 0xFFFF_FFFC -> 0, no flag).
//   4. else: hold.
//  Trap/redirect load regardless of en or fetch_ready_i (flush beats stall).
//   The in-flight fetch is abandoned; IMEM must tolerate the PC change while waiting.
//  halt_req_i in RUN: the same-cycle action above is still applied, then state <= HALT.
//  HALT: fetch_valid_o=0, halted_o=1, pc holds.
//   redirect_i loads pc (debugger writes dpc), with the same alignment check; trap_i is ignored.
//   resume_i -> RUN next cycle, even if halt_req_i is still high (it must be dropped first).
//   halt_req_i re-samples only after one cycle back in RUN.
//  Latency: every PC update is visible on pc_o the cycle after the triggering edge. No combinational input->pc_o path.
//  misalign_o is registered and deasserts after one cycle unless another misaligned redirect occurs.
// STRUCTURE
//  rv32_pkg: XLEN, RESET_VECTOR default, INSTR_BYTES=4, pc_state_e {BOOT, RUN, HALT}.
//  Single module, no sub-module: FSM, boot counter and PC datapath are kept together.
//  Boot counter width $clog2(BOOT_DELAY+1).
// TESTING
//  T1 reset: rst high for 3 cycles, then low -> pc_o=0x8000_0000; fetch_valid_o rises after exactly 4 cycles.
//  T2 advance/stall: ready=1, en=1 for 3 cycles -> pc 0x8000_0000, _04, _08, _0C.
//     en=0 -> holds _0C; ready=0 -> holds.
//  T3 priority: trap_i(vec 0x8000_0103) and redirect_i(0x8000_0200) in the same cycle, en=0 -> pc=0x8000_0100.
//  T4 misalign: redirect_pc_i=0x8000_0202 -> pc unchanged; misalign_o high 1 cycle; misalign_addr_o=0x8000_0202.
//  T5 halt: halt_req_i with redirect 0x8000_0400 -> pc=0x8000_0400, halted_o=1, fetch_valid_o=0.
//     Redirect 0x8000_0500 in HALT -> pc loads; resume_i -> RUN, fetch from 0x8000_0500.
//  T6 wrap/async: pc=0xFFFF_FFFC advances to 0x0. Assert rst mid-cycle -> pc_o=RESET_VECTOR before the next clk edge.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 core definitions used by the fetch-side units.
// Holds default widths, the reset vector and the PC unit state type.
package rv32_pkg;

  localparam int          XLEN         = 32;
  localparam logic [31:0] RESET_VECTOR = 32'h8000_0000;
  localparam int          INSTR_BYTES  = 4;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } pc_state_e;

endpackage

// File: rtl/pc_unit.sv
// Fetch program counter: boot delay, sequential advance, trap/branch
// redirects with alignment check, and a debug halt/resume state.
module pc_unit
  import rv32_pkg::*;
#(
  parameter int               XLEN         = rv32_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_VECTOR = rv32_pkg::RESET_VECTOR,
  parameter int               ALIGN_LOG2   = 2,
  parameter int               BOOT_DELAY   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            fetch_ready_i,
  output logic            fetch_valid_o,
  output logic [XLEN-1:0] pc_o,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_vec_i,
  input  logic            halt_req_i,
  input  logic            resume_i,
  output logic            halted_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] misalign_addr_o
);

  localparam int CW = $clog2(BOOT_DELAY + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(BOOT_DELAY - 1);
  localparam logic [XLEN-1:0] AMASK = XLEN'((1 << ALIGN_LOG2) - 1);
  localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);

  pc_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            mis_q, mis_d;
  logic [XLEN-1:0] mis_addr_q, mis_addr_d;
  logic            fresh_q, fresh_d;
  logic            redir_ok;

  assign redir_ok = (redirect_pc_i & AMASK) == '0;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    mis_d      = 1'b0;
    mis_addr_d = mis_addr_q;
    fresh_d    = 1'b0;
    unique case (state_q)
      BOOT: begin
        if (cnt_q == '0) state_d = RUN;
        else cnt_d = cnt_q - 1'b1;
      end
      RUN: begin
        if (trap_i) begin
          pc_d = trap_vec_i & ~AMASK;
        end else if (redirect_i) begin
          if (redir_ok) begin
            pc_d = redirect_pc_i;
          end else begin
            mis_d      = 1'b1;
            mis_addr_d = redirect_pc_i;
          end
        end else if (en && fetch_ready_i) begin
          pc_d = pc_q + STEP;
        end
        // a held halt_req is ignored for the first cycle after resume
        if (halt_req_i && !fresh_q) state_d = HALT;
      end
      HALT: begin
        if (redirect_i) begin
          if (redir_ok) begin
            pc_d = redirect_pc_i;
          end else begin
            mis_d      = 1'b1;
            mis_addr_d = redirect_pc_i;
          end
        end
        if (resume_i) begin
          state_d = RUN;
          fresh_d = 1'b1;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      cnt_q      <= CNT_INIT;
      pc_q       <= RESET_VECTOR;
      mis_q      <= 1'b0;
      mis_addr_q <= '0;
      fresh_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      mis_q      <= mis_d;
      mis_addr_q <= mis_addr_d;
      fresh_q    <= fresh_d;
    end
  end

  assign fetch_valid_o   = (state_q == RUN);
  assign halted_o        = (state_q == HALT);
  assign pc_o            = pc_q;
  assign misalign_o      = mis_q;
  assign misalign_addr_o = mis_addr_q;

endmodule
